// File: rtl/need_scheduler.sv
// rtl/need_scheduler.sv - action arbiter, cooldown sequencer and decay time base for the pet need FSMs
//
// Turns synchronized button levels (comer/jugar/descansar) into one-cycle,
// round-robin arbitrated action commands separated by a cooldown. It also
// produces the periodic decay pulses for the hunger/fun/energy FSMs.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   comer, jugar, descansar   request levels (synchronized)
//   acelerar                  fast time unit select
//   test                      every-cycle time unit (only with TEST_MODE_EN)
//   cmd_comer/jugar/descansar one-cycle action commands
//   decay_hambre/diversion/energia  one-cycle decay pulses
//   busy                      high in GRANT and COOLDOWN
//   ultimo                    last granted action (0 none, 1 comer, 2 jugar, 3 descansar)
//
// Optional feature macro: TEST_MODE_EN (test=1 forces a unit tick every cycle).

module need_scheduler #(
  parameter int UNIT_CYCLES    = 50_000_000,
  parameter int FAST_CYCLES    = 50_000,
  parameter int DECAY_UNITS    = 5,
  parameter int COOLDOWN_UNITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       comer,
  input  logic       jugar,
  input  logic       descansar,
  input  logic       acelerar,
  input  logic       test,
  output logic       cmd_comer,
  output logic       cmd_jugar,
  output logic       cmd_descansar,
  output logic       decay_hambre,
  output logic       decay_diversion,
  output logic       decay_energia,
  output logic       busy,
  output logic [1:0] ultimo
);

  localparam int MAX_CYCLES = (UNIT_CYCLES > FAST_CYCLES) ? UNIT_CYCLES : FAST_CYCLES;
  localparam int PW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [PW-1:0] UNIT_LAST  = PW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] FAST_LAST  = PW'(FAST_CYCLES - 1);
  localparam logic [3:0]    DECAY_LAST = 4'(DECAY_UNITS - 1);
  localparam logic [3:0]    CD_INIT    = 4'(COOLDOWN_UNITS);

  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

  state_t        state, state_nxt;
  logic [2:0]    req, prev, req_edge, pend;
  logic [1:0]    ptr;
  logic [3:0]    cd_cnt, dcnt;
  logic [PW-1:0] presc, presc_last;
  logic          unit_tick, wrap, granting;
  logic [2:0]    grant_vec, cmd_vec_nxt, wrap_vec;
  logic [2:0]    cmd_q, decay_q, defer;

  assign req      = {descansar, jugar, comer};
  assign req_edge = req & ~prev;

`ifdef TEST_MODE_EN
  always_comb begin
    presc_last = acelerar ? FAST_LAST : UNIT_LAST;
    if (test) presc_last = '0;
  end
`else
  logic unused_test;
  assign unused_test = test;
  assign presc_last  = acelerar ? FAST_LAST : UNIT_LAST;
`endif

  // ">=" rather than "==" so that switching to the short unit while the count
  // is already past its end still produces a tick and restarts the count.
  assign unit_tick = (presc >= presc_last);
  assign wrap      = unit_tick && (dcnt == DECAY_LAST);
  assign wrap_vec  = {3{wrap}};

  // Round-robin: ptr names the action with highest priority this round.
  always_comb begin
    grant_vec = 3'b000;
    case (ptr)
      2'd1: begin
        if      (pend[1]) grant_vec = 3'b010;
        else if (pend[2]) grant_vec = 3'b100;
        else if (pend[0]) grant_vec = 3'b001;
      end
      2'd2: begin
        if      (pend[2]) grant_vec = 3'b100;
        else if (pend[0]) grant_vec = 3'b001;
        else if (pend[1]) grant_vec = 3'b010;
      end
      default: begin
        if      (pend[0]) grant_vec = 3'b001;
        else if (pend[1]) grant_vec = 3'b010;
        else if (pend[2]) grant_vec = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    granting  = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = GRANT;
          granting  = 1'b1;
        end
      end
      GRANT:    state_nxt = COOLDOWN;
      COOLDOWN: if (unit_tick && cd_cnt == 4'd1) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign cmd_vec_nxt = granting ? grant_vec : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      pend    <= '0;
      ptr     <= '0;
      ultimo  <= '0;
      cd_cnt  <= '0;
      dcnt    <= '0;
      presc   <= '0;
      cmd_q   <= '0;
      decay_q <= '0;
      defer   <= '0;
    end else begin
      prev  <= req;
      presc <= unit_tick ? '0 : presc + 1'b1;
      if (unit_tick) dcnt <= wrap ? 4'd0 : dcnt + 4'd1;

      // Edges seen during COOLDOWN are discarded; earlier pending bits stay.
      if (state != COOLDOWN) pend <= (pend | req_edge) & ~cmd_vec_nxt;

      cmd_q <= cmd_vec_nxt;
      if (granting) begin
        cd_cnt <= CD_INIT;
        if (grant_vec[0]) begin
          ultimo <= 2'd1;
          ptr    <= 2'd1;
        end else if (grant_vec[1]) begin
          ultimo <= 2'd2;
          ptr    <= 2'd2;
        end else begin
          ultimo <= 2'd3;
          ptr    <= 2'd0;
        end
      end else if (state == COOLDOWN && unit_tick) begin
        cd_cnt <= cd_cnt - 4'd1;
      end

      // A decay colliding with its own action command is pushed back one
      // cycle so the need FSM (which favours the command) does not lose it.
      decay_q <= (wrap_vec & ~cmd_vec_nxt) | defer;
      defer   <= wrap_vec & cmd_vec_nxt;
    end
  end

  assign cmd_comer       = cmd_q[0];
  assign cmd_jugar       = cmd_q[1];
  assign cmd_descansar   = cmd_q[2];
  assign decay_hambre    = decay_q[0];
  assign decay_diversion = decay_q[1];
  assign decay_energia   = decay_q[2];
  assign busy            = (state != IDLE);

endmodule
